fsm_stim_sequencer: RTL and testbench

FSM_STIM_SEQUENCER -- requirements
Module: fsm_stim_sequencer

---
 rtl/fsm_stim_sequencer_if.sv | 26 ++
 rtl/fsm_stim_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fsm_stim_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_stim_sequencer_if.sv
// Handshake/bus bundle between a stimulus source (master) and fsm_stim_sequencer (slave).
interface fsm_stim_sequencer_if;
    logic       mode;
    logic       btn_in;
    logic [2:0] sw_in;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic [2:0] len;
    logic       start;
    logic       fsm_btn;
    logic [2:0] fsm_sw;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;

    modport master (
        output mode, btn_in, sw_in, wr_en, wr_addr, wr_data, len, start,
        input  fsm_btn, fsm_sw, busy, done, step_idx
    );

    modport slave (
        input  mode, btn_in, sw_in, wr_en, wr_addr, wr_data, len, start,
        output fsm_btn, fsm_sw, busy, done, step_idx
    );
endinterface

// File: rtl/fsm_stim_sequencer.sv
// Stimulus sequencer: manual debounced button/switch pass-through or programmed auto playback.
// Define SEQ_LOOP_EN to repeat the programmed sequence until mode drops or reset.
//
// state   | meaning
// IDLE    | manual pass-through, program memory writable
// APPLY   | present mem[step_idx] on fsm_sw (setup cycle)
// PULSE   | issue one fsm_btn pulse
// DWELL   | hold DWELL-1 cycles, then next step or finish
// DONE    | one-cycle done pulse, return to IDLE
module fsm_stim_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int DWELL      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fsm_stim_sequencer_if.slave  bus
);
    localparam int               DEB_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [7:0]       DWELL_LOAD = 8'(DWELL - 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_APPLY = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_DWELL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [2:0]       len_q, len_d;
    logic [7:0]       dwell_q, dwell_d;
    logic [2:0]       fsm_sw_q, fsm_sw_d;
    logic             fsm_btn_q, fsm_btn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       mem_q [8];
    logic [2:0]       mem_d [8];

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // Level flips only after DEB_LAST+1 consecutive samples that disagree with it.
    always_comb begin
        deb_cnt_d = '0;
        deb_d     = deb_q;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (bus.wr_en && !busy_q) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        len_d     = len_q;
        dwell_d   = dwell_q;
        fsm_sw_d  = fsm_sw_q;
        fsm_btn_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                fsm_sw_d  = bus.sw_in;
                // Edges seen outside IDLE are simply lost, never queued.
                fsm_btn_d = deb_q & ~deb_prev_q;
                if (bus.start && bus.mode) begin
                    state_d = S_APPLY;
                    step_d  = 3'd0;
                    len_d   = bus.len;
                end
            end
            S_APPLY: begin
                fsm_sw_d = mem_q[step_q];
                state_d  = S_PULSE;
            end
            S_PULSE: begin
                fsm_btn_d = 1'b1;
                dwell_d   = DWELL_LOAD;
                state_d   = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_q == 8'd0) begin
                    if (step_q == len_q) begin
`ifdef SEQ_LOOP_EN
                        done_d  = 1'b1;
                        step_d  = 3'd0;
                        state_d = S_APPLY;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_APPLY;
                    end
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_q != S_IDLE && !bus.mode) begin
            state_d   = S_IDLE;
            fsm_btn_d = 1'b0;
            done_d    = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            len_q      <= 3'd0;
            dwell_q    <= 8'd0;
            fsm_sw_q   <= 3'd0;
            fsm_btn_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            len_q      <= len_d;
            dwell_q    <= dwell_d;
            fsm_sw_q   <= fsm_sw_d;
            fsm_btn_q  <= fsm_btn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sync1_q    <= bus.btn_in;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.fsm_btn  = fsm_btn_q;
    assign bus.fsm_sw   = fsm_sw_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;
endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Self-checking bench for fsm_stim_sequencer: directed steps with randomized program contents.
module tb_fsm_stim_sequencer;
    localparam int DWELL = 16;
    localparam int STEP  = DWELL + 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [2:0] model_mem [8];

    fsm_stim_sequencer_if bus ();

    fsm_stim_sequencer #(.DEB_CYCLES(4), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_mem(input int a, input logic [2:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Cycle k = outputs seen after the k-th rising edge, counting the edge that samples start as 0.
    task automatic play(input int nlen, input bit disturb);
        int         dcyc;
        int         idx;
        logic [2:0] sw_hold;
        dcyc    = STEP * (nlen + 1) + 1;
        sw_hold = 3'($urandom_range(0, 7));
        bus.mode  = 1'b1;
        bus.sw_in = sw_hold;
        bus.len   = 3'(nlen);
        bus.start = 1'b1;
        for (int k = 0; k <= dcyc + 1; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("run_btn", 8'(bus.fsm_btn),
                8'(k >= 2 && (k - 2) % STEP == 0 && (k - 2) / STEP <= nlen));
            chk("run_done", 8'(bus.done), 8'(k == dcyc));
            if (k < dcyc) begin
                chk("run_busy", 8'(bus.busy), 8'd1);
                idx = k / STEP;
                if (idx > nlen) idx = nlen;
                chk("run_step", 8'(bus.step_idx), 8'(idx));
            end else begin
                chk("run_busy_end", 8'(bus.busy), 8'd0);
            end
            if (k >= 1 && k <= dcyc) begin
                idx = (k - 1) / STEP;
                if (idx > nlen) idx = nlen;
                chk("run_sw", 8'(bus.fsm_sw), 8'(model_mem[idx]));
            end
            if (k == dcyc + 1) chk("post_sw", 8'(bus.fsm_sw), 8'(sw_hold));
            if (disturb) begin
                if (k == 3) bus.btn_in = 1'b1;
                if (k == 5) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = 3'd0;
                    bus.wr_data = ~model_mem[0];
                    bus.start   = 1'b1;
                    bus.len     = 3'd0;
                end
                if (k == 6) bus.wr_en = 1'b0;
                if (k == 20) bus.btn_in = 1'b0;
            end
        end
    endtask

    initial begin
        int         pulses;
        int         first;
        int         dones;
        int         exp_p;
        int         exp_d;
        logic [2:0] v;

        rst         = 1'b1;
        bus.mode    = 1'b0;
        bus.btn_in  = 1'b0;
        bus.sw_in   = 3'd0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 3'd0;
        bus.len     = 3'd0;
        bus.start   = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_btn", 8'(bus.fsm_btn), 8'd0);
        chk("rst_sw", 8'(bus.fsm_sw), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        chk("rst_step", 8'(bus.step_idx), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Manual pass-through of switches, one cycle late.
        for (int i = 0; i < 6; i++) begin
            v = 3'($urandom_range(0, 7));
            bus.sw_in = v;
            @(negedge clk);
            chk("man_sw", 8'(bus.fsm_sw), 8'(v));
        end

        // Held button: exactly one pulse, 6..7 cycles after the assertion edge.
        bus.btn_in = 1'b1;
        pulses = 0;
        first  = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.fsm_btn === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 9) bus.btn_in = 1'b0;
        end
        chk("held_pulses", 8'(pulses), 8'd1);
        chk("held_latency_ok", 8'(first == 6 || first == 7), 8'd1);

        // Two-cycle glitch: no pulse.
        bus.btn_in = 1'b1;
        pulses = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (bus.fsm_btn === 1'b1) pulses++;
            if (k == 1) bus.btn_in = 1'b0;
        end
        chk("glitch_pulses", 8'(pulses), 8'd0);

        // start while mode=0 is ignored.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_mode0_busy", 8'(bus.busy), 8'd0);
        @(negedge clk);
        chk("start_mode0_busy2", 8'(bus.busy), 8'd0);

`ifndef SEQ_LOOP_EN
        write_mem(0, 3'd5);
        write_mem(1, 3'd2);
        write_mem(2, 3'd7);
        play(2, 1'b0);
        play($urandom_range(2, 7), 1'b1);
        play(0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 8; a++) write_mem(a, 3'($urandom_range(0, 7)));
            play($urandom_range(0, 7), 1'b0);
        end
`endif

        // Abort by dropping mode in DWELL of step 1.
        for (int a = 0; a < 4; a++) write_mem(a, 3'($urandom_range(0, 7)));
        bus.mode  = 1'b1;
        bus.len   = 3'd3;
        bus.start = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 19) chk("abort_step1_pulse", 8'(bus.fsm_btn), 8'd1);
        end
        bus.mode = 1'b0;
        @(negedge clk);
        chk("abort_busy", 8'(bus.busy), 8'd0);
        chk("abort_btn", 8'(bus.fsm_btn), 8'd0);
        chk("abort_done", 8'(bus.done), 8'd0);
        v = 3'($urandom_range(0, 7));
        bus.sw_in = v;
        @(negedge clk);
        chk("abort_sw_follow", 8'(bus.fsm_sw), 8'(v));
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("abort_no_done", 8'(dones), 8'd0);

        // Reset while in PULSE.
        for (int a = 0; a < 8; a++) write_mem(a, 3'($urandom_range(1, 7)));
        bus.mode  = 1'b1;
        bus.len   = 3'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_btn", 8'(bus.fsm_btn), 8'd0);
        chk("midrst_busy", 8'(bus.busy), 8'd0);
        chk("midrst_step", 8'(bus.step_idx), 8'd0);
        chk("midrst_sw", 8'(bus.fsm_sw), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) model_mem[a] = 3'd0;
        @(negedge clk);
        chk("postrst_done", 8'(bus.done), 8'd0);
`ifndef SEQ_LOOP_EN
        play(7, 1'b0);
`endif

        // len=1: two passes in loop builds, one pass otherwise.
        write_mem(0, 3'($urandom_range(0, 7)));
        write_mem(1, 3'($urandom_range(0, 7)));
`ifdef SEQ_LOOP_EN
        exp_p = 4;
        exp_d = 2;
`else
        exp_p = 2;
        exp_d = 1;
`endif
        pulses = 0;
        dones  = 0;
        bus.mode  = 1'b1;
        bus.len   = 3'd1;
        bus.start = 1'b1;
        for (int k = 0; k <= 68; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.fsm_btn === 1'b1) pulses++;
            if (bus.done === 1'b1) dones++;
        end
        bus.mode = 1'b0;
        @(negedge clk);
        chk("len1_pulses", 8'(pulses), 8'(exp_p));
        chk("len1_dones", 8'(dones), 8'(exp_d));
        chk("len1_idle", 8'(bus.busy), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
